tt_um_peter_william_gate_seq: RTL and testbench
===============================================

// Module: tt_um_peter_william_gate_seq
// PURPOSE
// - Parametrised successor to the single-NAND tile: a command-driven sequential gate evaluator.
// - Loads operands A and B over ui_in and evaluates one of 8 selectable bitwise ops.
// - Pushes each result into a DEPTH-entry result FIFO, read back on uo_out.
// - Top-level TinyTapeout user module; standard tt_um pinout, one clock domain.
// PARAMETERS
// - WIDTH  8  operand/result width (1..8); uo_out bits above WIDTH driven 0
// - DEPTH  4  result FIFO entries (2..8, any integer, not only pow2)
// PORTS
// - clk      in   1  system clock
// - rst_n    in   1  asynchronous, active-low reset
// - ena      in   1  tile enable; when low, strobes ignored, all state held
// - ui_in    in   8  data: operand value (LOAD_A/LOAD_B) or op code in [2:0] (EVAL)
// - uio_in   in   8  [2:0] cmd, [3] strobe (async pin); [7:4] unused
// - uo_out   out  8  FIFO head (zero-extended) when non-empty, else 8'h00
// - uio_out  out  8  [3:0]=0; [4] empty; [5] full; [6] overflow (sticky); [7] underflow (sticky)
// - uio_oe   out  8  constant 8'hF0
// BEHAVIOUR
// - Reset: A=B=ACC=0, FIFO empty, both sticky flags 0.
//   uo_out=8'h00, uio_out=8'h10, sync flops 0.
// - Strobe: uio_in[3] passes a 2-FF synchroniser; a third flop gives rising-edge detect.
//   Decode happens in the cycle the edge pulse is high (3 clk after the pin rises).
//   cmd and ui_in are sampled in that cycle; the host holds them stable >=4 clk.
// - One command per edge.
//   A held-high strobe issues exactly one command.
// - Commands (cmd):
//   - 000 NOP.
//   - 001 LOAD_A: A<=ui_in[WIDTH-1:0].
//   - 010 LOAD_B: B<=ui_in[WIDTH-1:0].
//   - 011 EVAL: compute op=ui_in[2:0] and push the result.
//   - 100 POP: drop the FIFO head.
//   - 101 CLEAR: empty the FIFO and clear the stickies; A/B/ACC kept.
//   - 110/111 NOP.
// - Ops:
//   - 000 NAND ~(A&B)
//   - 001 AND
//   - 010 OR
//   - 011 NOR
//   - 100 XOR
//   - 101 XNOR
//   - 110 NOT A
//   - 111 see CONFIGURATION
// - Latency: the FIFO update is registered in the decode cycle.
//   New uo_out/status visible one clk after decode.
// - FIFO full + EVAL: result dropped, contents unchanged, overflow<=1.
// - FIFO empty + POP: no change, underflow<=1.
// - Pointers wrap modulo DEPTH; count is 0..DEPTH.
// - uo_out and flags are combinational from registered FIFO state (no extra stage).
// - ena low: the edge detector still tracks the pin, so no stale edge fires when ena rises.
//   Decode is suppressed.
// - rst_n asserted mid-command: everything clears immediately.
//   The pending edge is lost and is not replayed after release.
// CONFIGURATION
// - GATE_SEQ_ACC_EN defined:
//   - op 111 = ACC_NAND: ACC<=~(ACC&A).
//   - The new ACC value is pushed; if the FIFO is full, ACC still updates and overflow<=1.
//   - CLEAR does not touch ACC; only reset clears it.
// - GATE_SEQ_ACC_EN undefined:
//   - No ACC register.
//   - op 111 aliases NAND ~(A&B).
// STRUCTURE
// - Package gate_seq_pkg:
//   - cmd_e (NOP/LOAD_A/LOAD_B/EVAL/POP/CLEAR).
//   - op_e (8 ops).
//   - status bit index localparams (ST_EMPTY=4, ST_FULL=5, ST_OVF=6, ST_UNF=7).
//   - UIO_OE_MASK=8'hF0.
// - Sub-module gate_seq_fifo #(WIDTH,DEPTH):
//   - ports clk, rst_n, push, pop, din, dout, empty, full.
//   - Push when full and pop when empty are ignored inside the FIFO.
//   - The top level owns the sticky flags.
// - Top level: synchroniser/edge detect, command decoder, operand/ACC registers, op ALU.
// TESTING
// - Reset, then run LOAD_A 0xF0, LOAD_B 0xCC, EVAL op 000.
//   Expect uo_out=0x3F and uio_out[4]=0 one clk after decode.
// - A=0xAA, B=0x0F: EVAL ops 001,010,100 then POP x3.
//   Expect head sequence 0x0A, 0xAF, 0xA5, then uo_out=0x00 and empty=1.
// - EVAL DEPTH+1 times.
//   Expect full=1 after DEPTH pushes; the extra push sets overflow and the head is unchanged.
//   CLEAR then gives empty=1, overflow=0.
// - POP on empty: underflow=1, uo_out=0x00. Strobe held high 20 clk issues exactly one command.
// - With GATE_SEQ_ACC_EN, A=0xFF: EVAL op 111 twice gives 0xFF then 0x00.
//   Without the macro, op 111 equals the NAND result.
// - Assert rst_n low between the strobe edge and decode: no result is pushed and outputs read reset values.
//   ena=0 strobe: state unchanged.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Purpose: shared command/op encodings, status bit positions and the bitwise gate helper.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package gate_seq_pkg;

    // Host command on uio_in[2:0]; 110/111 are reserved and decode as NOP.
    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_LOAD_A = 3'd1,
        CMD_LOAD_B = 3'd2,
        CMD_EVAL   = 3'd3,
        CMD_POP    = 3'd4,
        CMD_CLEAR  = 3'd5,
        CMD_RSVD6  = 3'd6,
        CMD_RSVD7  = 3'd7
    } cmd_e;

    // Gate selector on ui_in[2:0] during EVAL.
    typedef enum logic [2:0] {
        OP_NAND     = 3'd0,
        OP_AND      = 3'd1,
        OP_OR       = 3'd2,
        OP_NOR      = 3'd3,
        OP_XOR      = 3'd4,
        OP_XNOR     = 3'd5,
        OP_NOT_A    = 3'd6,
        OP_ACC_NAND = 3'd7
    } op_e;

    // uio_out bit positions for the status flags.
    localparam int ST_EMPTY = 4;
    localparam int ST_FULL  = 5;
    localparam int ST_OVF   = 6;
    localparam int ST_UNF   = 7;

    // Upper nibble of uio is output, lower nibble is input.
    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    // Stateless gate evaluation on full 8-bit lanes; callers truncate to WIDTH.
    // OP_ACC_NAND falls back to plain NAND; the accumulator variant lives in the top.
    function automatic logic [7:0] gate_eval(input op_e op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            OP_NAND:  r = ~(a & b);
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_NOR:   r = ~(a | b);
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            OP_NOT_A: r = ~a;
            default:  r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_seq_fifo.sv
// Purpose: DEPTH-entry result FIFO with modulo-DEPTH pointers (DEPTH need not be a power of two).
// Latency: push/pop/clr registered on the clock edge; dout/empty/full are combinational from state.
// Backpressure: push while full and pop while empty are silently ignored; caller tracks the error.
//
// Ports: clk, rst_n (async active-low), clr (synchronous flush), push/din, pop,
//        dout (head entry, undefined when empty), empty, full.
module gate_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full & ~clr;
    assign do_pop  = pop & ~empty & ~clr;
    assign dout    = mem[rd_ptr];

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked by empty at the top level.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tt_um_peter_william_gate_seq.sv
// Purpose: command-driven sequential gate evaluator; loads A/B, evaluates a bitwise op, queues results.
// Latency: command decoded 3 clk after the strobe pin rises; result/status visible 1 clk after decode.
// Backpressure: none to the host; EVAL into a full FIFO drops the result and sets sticky overflow.
//
// Ports: ui_in   - operand (LOAD_A/LOAD_B) or op code in [2:0] (EVAL)
//        uio_in  - [2:0] cmd, [3] async strobe, [7:4] unused
//        uo_out  - FIFO head zero-extended, 8'h00 when empty
//        uio_out - [4] empty, [5] full, [6] overflow, [7] underflow, [3:0] zero
//        uio_oe  - constant 8'hF0
//        ena, clk, rst_n (async active-low)
// Option: define GATE_SEQ_ACC_EN to make op 111 an accumulating NAND (ACC <= ~(ACC & A)).
module tt_um_peter_william_gate_seq
    import gate_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    // ---------------------------------------------------------------
    // Strobe synchroniser + rising-edge detect.
    // [0],[1] form the 2-FF synchroniser, [2] holds the previous value.
    // Runs regardless of ena so a strobe that rose while disabled is
    // already "seen" and cannot fire later when ena goes high.
    // ---------------------------------------------------------------
    logic [2:0] strb_sync_q;
    logic       strb_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) strb_sync_q <= '0;
        else        strb_sync_q <= {strb_sync_q[1:0], uio_in[3]};
    end

    assign strb_pulse = strb_sync_q[1] & ~strb_sync_q[2];

    // ---------------------------------------------------------------
    // Operand registers and ALU
    // ---------------------------------------------------------------
    cmd_e             cmd;
    op_e              op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [7:0]       a_ext;
    logic [7:0]       b_ext;
    logic [7:0]       alu8;
    logic [WIDTH-1:0] result;

    assign cmd  = cmd_e'(uio_in[2:0]);
    assign op   = op_e'(ui_in[2:0]);
    assign data = ui_in[WIDTH-1:0];

`ifdef GATE_SEQ_ACC_EN
    logic [WIDTH-1:0] acc_q;
`endif

    always_comb begin
        a_ext             = '0;
        b_ext             = '0;
        a_ext[WIDTH-1:0]  = a_q;
        b_ext[WIDTH-1:0]  = b_q;
        alu8              = gate_eval(op, a_ext, b_ext);
        result            = alu8[WIDTH-1:0];
`ifdef GATE_SEQ_ACC_EN
        if (op == OP_ACC_NAND) result = ~(acc_q & a_q);
`endif
    end

    // ---------------------------------------------------------------
    // Command decode: only in the single pulse cycle, and only when enabled.
    // ---------------------------------------------------------------
    logic load_a;
    logic load_b;
    logic eval_cmd;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_clr;
    logic fifo_empty;
    logic fifo_full;
    logic [WIDTH-1:0] fifo_head;

    always_comb begin
        load_a    = 1'b0;
        load_b    = 1'b0;
        eval_cmd  = 1'b0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        fifo_clr  = 1'b0;
        if (ena && strb_pulse) begin
            case (cmd)
                CMD_LOAD_A: load_a = 1'b1;
                CMD_LOAD_B: load_b = 1'b1;
                CMD_EVAL: begin
                    eval_cmd  = 1'b1;
                    fifo_push = 1'b1;
                end
                CMD_POP:    fifo_pop = 1'b1;
                CMD_CLEAR:  fifo_clr = 1'b1;
                default:    ;
            endcase
        end
    end

    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (load_a) a_q <= data;
            if (load_b) b_q <= data;
            if (fifo_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (fifo_push && fifo_full)  ovf_q <= 1'b1;
                if (fifo_pop  && fifo_empty) unf_q <= 1'b1;
            end
        end
    end

`ifdef GATE_SEQ_ACC_EN
    // ACC advances even when the push is dropped; CLEAR leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            acc_q <= '0;
        else if (eval_cmd && op == OP_ACC_NAND) acc_q <= result;
    end
`endif

    gate_seq_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (result),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // ---------------------------------------------------------------
    // Outputs: straight from registered FIFO/flag state.
    // ---------------------------------------------------------------
    always_comb begin
        uo_out = 8'h00;
        if (!fifo_empty) uo_out[WIDTH-1:0] = fifo_head;
        uio_out           = 8'h00;
        uio_out[ST_EMPTY] = fifo_empty;
        uio_out[ST_FULL]  = fifo_full;
        uio_out[ST_OVF]   = ovf_q;
        uio_out[ST_UNF]   = unf_q;
        uio_oe            = UIO_OE_MASK;
    end

    logic unused_pins;
    assign unused_pins = &{1'b0, uio_in[7:4], ui_in, alu8, eval_cmd};

endmodule

// File: tb/tb_tt_um_peter_william_gate_seq.sv
module tb_tt_um_peter_william_gate_seq;

    localparam int DEPTH = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena   = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_peter_william_gate_seq #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: a queue of results plus operand/flag state.
    logic [7:0] m_q[$];
    logic [7:0] m_a, m_b, m_acc;
    bit         m_ovf, m_unf;

    task automatic model_reset();
        m_q.delete();
        m_a = 8'h00; m_b = 8'h00; m_acc = 8'h00;
        m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_apply(input logic [2:0] cmd, input logic [7:0] data);
        logic [7:0] r;
        case (cmd)
            3'd1: m_a = data;
            3'd2: m_b = data;
            3'd3: begin
                case (data[2:0])
                    3'd0: r = ~(m_a & m_b);
                    3'd1: r = m_a & m_b;
                    3'd2: r = m_a | m_b;
                    3'd3: r = ~(m_a | m_b);
                    3'd4: r = m_a ^ m_b;
                    3'd5: r = ~(m_a ^ m_b);
                    3'd6: r = ~m_a;
                    default: begin
`ifdef GATE_SEQ_ACC_EN
                        m_acc = ~(m_acc & m_a);
                        r = m_acc;
`else
                        r = ~(m_a & m_b);
`endif
                    end
                endcase
                if (m_q.size() < DEPTH) m_q.push_back(r);
                else m_ovf = 1'b1;
            end
            3'd4: begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_unf = 1'b1;
            end
            3'd5: begin
                m_q.delete();
                m_ovf = 1'b0; m_unf = 1'b0;
            end
            default: ;
        endcase
    endtask

    function automatic logic [7:0] exp_uo();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_uio();
        return {m_unf, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0), 4'h0};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_uo_out",  uo_out,  exp_uo());
            check("cyc_uio_out", uio_out, exp_uio());
            check("cyc_uio_oe",  uio_oe,  8'hF0);
        end
    end

    // Raise the strobe with cmd/data, mirror the command into the model at the
    // decode edge (3rd rising clk after the pin rises), keep the strobe high for
    // hold_hi extra cycles, then drop it. Returns one negedge after decode when hold_hi=0.
    task automatic issue(input logic [2:0] cmd, input logic [7:0] data, input int hold_hi, input bit applies);
        repeat (4) @(negedge clk);
        ui_in  = data;
        uio_in = {4'h0, 1'b1, cmd};
        repeat (3) @(posedge clk);
        if (applies) model_apply(cmd, data);
        @(negedge clk);
        repeat (hold_hi) @(negedge clk);
        uio_in[3] = 1'b0;
    endtask

    task automatic go(input logic [2:0] cmd, input logic [7:0] data);
        issue(cmd, data, 0, 1'b1);
    endtask

    initial begin
        model_reset();
        // ---- reset ----
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_uo_out",  uo_out,  8'h00);
        check("rst_uio_out", uio_out, 8'h10);
        check("rst_uio_oe",  uio_oe,  8'hF0);
        @(posedge clk); #1 rst_n = 1'b1;

        // ---- basic NAND ----
        go(3'd1, 8'hF0);
        go(3'd2, 8'hCC);
        go(3'd3, 8'h00);
        check("nand_uo_out", uo_out, 8'h3F);
        check("nand_empty",  {7'h0, uio_out[4]}, 8'h00);

        // ---- AND/OR/XOR then pops ----
        go(3'd5, 8'h00);
        go(3'd1, 8'hAA);
        go(3'd2, 8'h0F);
        go(3'd3, 8'h01);
        go(3'd3, 8'h02);
        go(3'd3, 8'h04);
        check("seq_head0", uo_out, 8'h0A);
        go(3'd4, 8'h00);
        check("seq_head1", uo_out, 8'hAF);
        go(3'd4, 8'h00);
        check("seq_head2", uo_out, 8'hA5);
        go(3'd4, 8'h00);
        check("seq_drained_uo",  uo_out,  8'h00);
        check("seq_drained_uio", uio_out, 8'h10);

        // ---- fill to DEPTH, overflow, clear ----
        for (int i = 0; i < DEPTH; i++) go(3'd3, 8'(i));
        check("fill_full", {7'h0, uio_out[5]}, 8'h01);
        check("fill_head", uo_out, 8'hF5);
        go(3'd3, 8'h04);
        check("ovf_uio",  uio_out, 8'h60);
        check("ovf_head", uo_out,  8'hF5);
        go(3'd5, 8'h00);
        check("clr_uio", uio_out, 8'h10);

        // ---- underflow, held strobe ----
        go(3'd4, 8'h00);
        check("unf_uio", uio_out, 8'h90);
        check("unf_uo",  uo_out,  8'h00);
        go(3'd5, 8'h00);
        issue(3'd3, 8'h06, 20, 1'b1);
        repeat (6) @(negedge clk);
        check("held_uo",  uo_out,  8'h55);
        check("held_uio", uio_out, 8'h00);
        go(3'd4, 8'h00);
        check("held_one_cmd", uio_out, 8'h10);

        // ---- op 111 ----
        go(3'd1, 8'hFF);
        go(3'd3, 8'h07);
        go(3'd3, 8'h07);
`ifdef GATE_SEQ_ACC_EN
        check("op7_first", uo_out, 8'hFF);
        go(3'd4, 8'h00);
        check("op7_second", uo_out, 8'h00);
`else
        check("op7_first", uo_out, 8'hF0);
        go(3'd4, 8'h00);
        check("op7_second", uo_out, 8'hF0);
`endif
        go(3'd5, 8'h00);

        // ---- reset between strobe edge and decode ----
        go(3'd3, 8'h00);
        repeat (4) @(negedge clk);
        ui_in  = 8'h00;
        uio_in = {4'h0, 1'b1, 3'd3};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        uio_in[3] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("midrst_uo",  uo_out,  8'h00);
        check("midrst_uio", uio_out, 8'h10);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_replay", uio_out, 8'h10);

        // ---- ena low ----
        go(3'd1, 8'h5A);
        go(3'd2, 8'h3C);
        @(negedge clk); ena = 1'b0;
        issue(3'd1, 8'h12, 0, 1'b0);
        issue(3'd3, 8'h00, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("ena0_no_push", uio_out, 8'h10);
        // strobe rises while disabled and is still high when ena returns
        uio_in = {4'h0, 1'b1, 3'd2};
        ui_in  = 8'h33;
        repeat (6) @(negedge clk);
        ena = 1'b1;
        repeat (6) @(negedge clk);
        uio_in[3] = 1'b0;
        go(3'd3, 8'h01);
        check("ena_operands_held", uo_out, 8'h18);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
